// File: rtl/usb_rx_decoder_if.sv
// Buffer and controller side of the USB receive decoder.
// master: the decoder (drives payload, strobes and status).
// slave: the data buffer / protocol controller (drives buffer_occupancy).
// Strobe semantics: RX_packet_data is valid only in a cycle where
// store_RX_packet_data=1. There is no back-pressure; a full buffer is
// reported through buffer_occupancy and the decoder drops the byte.
interface usb_rx_decoder_if;
  logic [7:0] RX_packet_data;
  logic       store_RX_packet_data;
  logic       flush;
  logic [2:0] RX_packet;
  logic       RX_data_ready;
  logic       RX_transfer_active;
  logic       RX_error;
  logic [6:0] buffer_occupancy;

  modport master (
    output RX_packet_data, store_RX_packet_data, flush, RX_packet,
           RX_data_ready, RX_transfer_active, RX_error,
    input  buffer_occupancy
  );

  modport slave (
    input  RX_packet_data, store_RX_packet_data, flush, RX_packet,
           RX_data_ready, RX_transfer_active, RX_error,
    output buffer_occupancy
  );
endinterface

// File: rtl/usb_rx_decoder.sv
// USB full-speed-style receive front end: synchronises D+/D-, recovers bit
// timing from D+ edges, NRZI-decodes LSB-first, checks SYNC/PID/token
// address and writes DATA payload bytes to the buffer.
// Optional feature macro: BIT_UNSTUFF_EN (bit unstuffing after six 1s).
// The FSM state is visible on dbg_state_o.
module usb_rx_decoder #(
  parameter int         BIT_PERIOD  = 8,
  parameter logic [6:0] DEVICE_ADDR = 7'd0,
  parameter int         BUFFER_SIZE = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dplus_in,
  input  logic              dminus_in,
  usb_rx_decoder_if.master  bus,
  output logic [2:0]        dbg_state_o
);

  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(BIT_PERIOD / 2 - 1);
  localparam logic [CW-1:0] J_LAST    = CW'(BIT_PERIOD - 1);

  localparam logic [2:0] PKT_NONE  = 3'd0;
  localparam logic [2:0] PKT_ACK   = 3'd1;
  localparam logic [2:0] PKT_NAK   = 3'd2;
  localparam logic [2:0] PKT_STALL = 3'd3;
  localparam logic [2:0] PKT_DATA0 = 3'd4;
  localparam logic [2:0] PKT_DATA1 = 3'd5;
  localparam logic [2:0] PKT_OUT   = 3'd6;
  localparam logic [2:0] PKT_IN    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOP, S_ERROR
  } state_t;

  // Line front end
  logic          dp_s1_q, dp_s2_q, dp_s3_q, dm_s1_q, dm_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_dp_q, prev_dp_d;
  logic          dp_edge, k_edge, sample, se0, is_j, rx_bit;

  // FSM and datapath
  state_t        state_q, state_d;
  logic [6:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    pid_q, pid_d;
  logic          tok_idx_q, tok_idx_d;
  logic [6:0]    addr_q, addr_d;
  logic [1:0]    eop_cnt_q, eop_cnt_d;
  logic [CW-1:0] j_cnt_q, j_cnt_d;

  // Registered outputs
  logic [7:0]    data_q, data_d;
  logic          store_q, store_d;
  logic          flush_q, flush_d;
  logic [2:0]    packet_q, packet_d;
  logic          ready_q, ready_d;
  logic          active_q, active_d;
  logic          error_q, error_d;

  logic          receiving, stuff_skip, stuff_err;
  logic          rx_bit_valid, byte_done, line_bad, buf_full;
  logic [7:0]    byte_val;

  assign dp_edge   = dp_s2_q ^ dp_s3_q;
  assign k_edge    = dp_s3_q & ~dp_s2_q & dm_s2_q;
  assign cnt_d     = dp_edge ? '0 : cnt_q + CW'(1);
  assign sample    = (cnt_q == SAMPLE_AT);
  assign se0       = ~dp_s2_q & ~dm_s2_q;
  assign is_j      = dp_s2_q & ~dm_s2_q;
  assign rx_bit    = ~(dp_s2_q ^ prev_dp_q);
  assign prev_dp_d = (sample && !se0) ? dp_s2_q : prev_dp_q;

  assign receiving    = (state_q == S_SYNC) || (state_q == S_PID) ||
                        (state_q == S_TOKEN) || (state_q == S_DATA);
  assign rx_bit_valid = receiving && sample && !se0 && !stuff_skip;
  assign byte_done    = rx_bit_valid && (bit_idx_q == 3'd7);
  assign byte_val     = {rx_bit, shift_q};
  assign line_bad     = sample && (se0 || stuff_err);
  assign buf_full     = (bus.buffer_occupancy == 7'(BUFFER_SIZE));

  // Synchroniser, bit-phase counter and NRZI reference bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_s1_q   <= 1'b1;
      dp_s2_q   <= 1'b1;
      dp_s3_q   <= 1'b1;
      dm_s1_q   <= 1'b0;
      dm_s2_q   <= 1'b0;
      cnt_q     <= '0;
      prev_dp_q <= 1'b1;
    end else begin
      dp_s1_q   <= dplus_in;
      dp_s2_q   <= dp_s1_q;
      dp_s3_q   <= dp_s2_q;
      dm_s1_q   <= dminus_in;
      dm_s2_q   <= dm_s1_q;
      cnt_q     <= cnt_d;
      prev_dp_q <= prev_dp_d;
    end
  end

`ifdef BIT_UNSTUFF_EN
  logic [2:0] ones_q, ones_d;

  // Track the run of decoded 1s; the sample after six 1s is a stuff bit
  always_comb begin
    ones_d     = ones_q;
    stuff_skip = 1'b0;
    stuff_err  = 1'b0;
    if (!receiving) begin
      ones_d = '0;
    end else if (sample) begin
      if (se0) begin
        ones_d = '0;
      end else if (ones_q == 3'd6) begin
        stuff_skip = 1'b1;
        stuff_err  = rx_bit;
        ones_d     = '0;
      end else if (rx_bit) begin
        ones_d = ones_q + 3'd1;
      end else begin
        ones_d = '0;
      end
    end
  end

  // Ones-run register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ones_q <= '0;
    else        ones_q <= ones_d;
  end
`else
  assign stuff_skip = 1'b0;
  assign stuff_err  = 1'b0;
`endif

  // Packet FSM next state and registered outputs
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pid_d     = pid_q;
    tok_idx_d = tok_idx_q;
    addr_d    = addr_q;
    eop_cnt_d = eop_cnt_q;
    j_cnt_d   = '0;
    data_d    = data_q;
    store_d   = 1'b0;
    flush_d   = 1'b0;
    packet_d  = packet_q;
    ready_d   = 1'b0;
    active_d  = active_q;
    error_d   = error_q;

    if (rx_bit_valid) begin
      shift_d   = {rx_bit, shift_q[6:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        bit_idx_d = '0;
        if (k_edge) begin
          state_d  = S_SYNC;
          active_d = 1'b1;
          error_d  = 1'b0;
        end
      end
      S_SYNC: begin
        if (line_bad) state_d = S_ERROR;
        else if (byte_done) state_d = (byte_val == 8'h80) ? S_PID : S_ERROR;
      end
      S_PID: begin
        if (line_bad) begin
          state_d = S_ERROR;
        end else if (byte_done) begin
          eop_cnt_d = 2'd0;
          tok_idx_d = 1'b0;
          case (byte_val)
            8'h2D: begin pid_d = PKT_ACK;   state_d = S_EOP; end
            8'hA5: begin pid_d = PKT_NAK;   state_d = S_EOP; end
            8'hE1: begin pid_d = PKT_STALL; state_d = S_EOP; end
            8'h33: begin pid_d = PKT_DATA0; state_d = S_DATA; flush_d = 1'b1; end
            8'hB4: begin pid_d = PKT_DATA1; state_d = S_DATA; flush_d = 1'b1; end
            8'h87: begin pid_d = PKT_OUT;   state_d = S_TOKEN; end
            8'h96: begin pid_d = PKT_IN;    state_d = S_TOKEN; end
            default: state_d = S_ERROR;
          endcase
        end
      end
      S_TOKEN: begin
        if (line_bad) begin
          state_d = S_ERROR;
        end else if (byte_done) begin
          if (!tok_idx_q) begin
            addr_d    = byte_val[6:0];
            tok_idx_d = 1'b1;
          end else begin
            state_d   = S_EOP;
            eop_cnt_d = 2'd0;
          end
        end
      end
      S_DATA: begin
        if (sample && se0) begin
          // SE0 is only legal on a byte boundary, where it opens the EOP
          if (bit_idx_q == 3'd0) begin
            state_d   = S_EOP;
            eop_cnt_d = 2'd1;
          end else begin
            state_d = S_ERROR;
          end
        end else if (line_bad) begin
          state_d = S_ERROR;
        end else if (byte_done) begin
          if (buf_full) begin
            state_d = S_ERROR;
          end else begin
            data_d  = byte_val;
            store_d = 1'b1;
          end
        end
      end
      S_EOP: begin
        if (sample) begin
          if (se0) begin
            if (eop_cnt_q < 2'd2) eop_cnt_d = eop_cnt_q + 2'd1;
            else                  state_d   = S_ERROR;
          end else if (is_j && eop_cnt_q == 2'd2) begin
            state_d  = S_IDLE;
            active_d = 1'b0;
            ready_d  = (pid_q == PKT_DATA0) || (pid_q == PKT_DATA1);
            // A token for another device is silently ignored
            if ((pid_q == PKT_OUT || pid_q == PKT_IN) && addr_q != DEVICE_ADDR)
              packet_d = PKT_NONE;
            else
              packet_d = pid_q;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        error_d  = 1'b1;
        packet_d = PKT_NONE;
        j_cnt_d  = j_cnt_q;
        if (sample) begin
          if (!is_j) begin
            j_cnt_d = '0;
          end else if (j_cnt_q == J_LAST) begin
            j_cnt_d  = '0;
            state_d  = S_IDLE;
            active_d = 1'b0;
          end else begin
            j_cnt_d = j_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, datapath and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      pid_q     <= PKT_NONE;
      tok_idx_q <= 1'b0;
      addr_q    <= '0;
      eop_cnt_q <= '0;
      j_cnt_q   <= '0;
      data_q    <= '0;
      store_q   <= 1'b0;
      flush_q   <= 1'b0;
      packet_q  <= PKT_NONE;
      ready_q   <= 1'b0;
      active_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      pid_q     <= pid_d;
      tok_idx_q <= tok_idx_d;
      addr_q    <= addr_d;
      eop_cnt_q <= eop_cnt_d;
      j_cnt_q   <= j_cnt_d;
      data_q    <= data_d;
      store_q   <= store_d;
      flush_q   <= flush_d;
      packet_q  <= packet_d;
      ready_q   <= ready_d;
      active_q  <= active_d;
      error_q   <= error_d;
    end
  end

  assign bus.RX_packet_data       = data_q;
  assign bus.store_RX_packet_data = store_q;
  assign bus.flush                = flush_q;
  assign bus.RX_packet            = packet_q;
  assign bus.RX_data_ready        = ready_q;
  assign bus.RX_transfer_active   = active_q;
  assign bus.RX_error             = error_q;
  assign dbg_state_o              = state_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench for usb_rx_decoder: NRZI line driver, store-strobe
// scoreboard and status checks after each packet.
module tb_usb_rx_decoder;

  localparam int BP = 8;

  logic clk;
  logic n_rst;
  logic dplus, dminus;
  logic line_j;
  logic [2:0] dbg_state;

  usb_rx_decoder_if bus();

  usb_rx_decoder #(
    .BIT_PERIOD  (BP),
    .DEVICE_ADDR (7'd5),
    .BUFFER_SIZE (64)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .dplus_in    (dplus),
    .dminus_in   (dminus),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int store_cnt = 0;
  int flush_cnt = 0;
  int ready_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every store strobe must match the next driven payload byte
  always @(negedge clk) begin
    if (bus.store_RX_packet_data) begin
      store_cnt++;
      check("store_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("store_data", bus.RX_packet_data, exp_q.pop_front());
    end
    if (bus.flush) flush_cnt++;
    if (bus.RX_data_ready) ready_cnt++;
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic drive_bit_time(input logic dp, input logic dm);
    dplus  = dp;
    dminus = dm;
    repeat (BP) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (!b) line_j = ~line_j;
    drive_bit_time(line_j, ~line_j);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_eop();
    drive_bit_time(1'b0, 1'b0);
    drive_bit_time(1'b0, 1'b0);
    line_j = 1'b1;
    drive_bit_time(1'b1, 1'b0);
  endtask

  task automatic idle_bits(input int n);
    line_j = 1'b1;
    for (int i = 0; i < n; i++) drive_bit_time(1'b1, 1'b0);
  endtask

  task automatic clear_counts();
    store_cnt = 0;
    flush_cnt = 0;
    ready_cnt = 0;
  endtask

  task automatic send_handshake(input logic [7:0] pid);
    send_byte(8'h80);
    send_byte(pid);
    send_eop();
    idle_bits(12);
  endtask

  task automatic check_status(input string tag, input logic [2:0] pkt, input logic err);
    check({tag, "_packet"}, bus.RX_packet, pkt);
    check({tag, "_error"},  bus.RX_error, err);
    check({tag, "_active"}, bus.RX_transfer_active, 0);
  endtask

  logic [7:0] rb;

  initial begin
    n_rst = 1'b0;
    dplus = 1'b1;
    dminus = 1'b0;
    line_j = 1'b1;
    bus.buffer_occupancy = 7'd0;
    repeat (3) @(negedge clk);

    check("rst_data",   bus.RX_packet_data, 0);
    check("rst_store",  bus.store_RX_packet_data, 0);
    check("rst_flush",  bus.flush, 0);
    check("rst_packet", bus.RX_packet, 0);
    check("rst_ready",  bus.RX_data_ready, 0);
    check("rst_active", bus.RX_transfer_active, 0);
    check("rst_error",  bus.RX_error, 0);
    check("rst_state",  dbg_state, 0);
    n_rst = 1'b1;
    idle_bits(4);

    // ACK
    clear_counts();
    send_byte(8'h80);
    check("ack_active_mid", bus.RX_transfer_active, 1);
    send_byte(8'h2D);
    send_eop();
    idle_bits(12);
    check_status("ack", 3'd1, 1'b0);
    check("ack_stores", store_cnt, 0);
    check("ack_ready", ready_cnt, 0);

    // DATA0 with five payload bytes
    clear_counts();
    send_byte(8'h80);
    send_byte(8'h33);
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i));
    end
    send_eop();
    idle_bits(12);
    check_status("data0", 3'd4, 1'b0);
    check("data0_flush", flush_cnt, 1);
    check("data0_stores", store_cnt, 5);
    check("data0_ready", ready_cnt, 1);

    // OUT to our address; RX_packet must hold 4 while the packet runs
    clear_counts();
    send_byte(8'h80);
    check("out_pkt_hold", bus.RX_packet, 4);
    send_byte(8'h87);
    send_byte(8'h05);
    send_byte(8'h28);
    send_eop();
    idle_bits(12);
    check_status("out_match", 3'd6, 1'b0);
    check("out_ready", ready_cnt, 0);

    // OUT to another address
    send_byte(8'h80);
    send_byte(8'h87);
    send_byte(8'h06);
    send_byte(8'h28);
    send_eop();
    idle_bits(12);
    check_status("out_other", 3'd0, 1'b0);

    // Corrupt SYNC, then a NAK recovers
    send_handshake(8'h2D);
    send_handshake(8'hA5);
    check_status("nak1", 3'd2, 1'b0);
    send_byte(8'h81);
    send_byte(8'h2D);
    send_eop();
    idle_bits(12);
    check_status("bad_sync", 3'd0, 1'b1);
    send_handshake(8'hA5);
    check_status("nak2", 3'd2, 1'b0);

    // Unknown PID
    send_handshake(8'h00);
    check_status("bad_pid", 3'd0, 1'b1);
    send_handshake(8'hA5);
    check_status("nak3", 3'd2, 1'b0);

    // DATA1 into a full buffer
    clear_counts();
    bus.buffer_occupancy = 7'd64;
    send_byte(8'h80);
    send_byte(8'hB4);
    send_byte(8'h11);
    send_byte(8'h22);
    send_eop();
    idle_bits(12);
    bus.buffer_occupancy = 7'd0;
    check_status("full", 3'd0, 1'b1);
    check("full_stores", store_cnt, 0);
    check("full_flush", flush_cnt, 1);
    check("full_ready", ready_cnt, 0);
    send_handshake(8'hA5);
    check_status("nak4", 3'd2, 1'b0);

    // SE0 three bits into a data byte
    clear_counts();
    send_byte(8'h80);
    send_byte(8'h33);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_eop();
    idle_bits(12);
    check_status("short_byte", 3'd0, 1'b1);
    check("short_stores", store_cnt, 0);
    check("short_ready", ready_cnt, 0);

    // DATA1 with random payload, buffer one below full
    clear_counts();
    bus.buffer_occupancy = 7'd63;
    send_byte(8'h80);
    send_byte(8'hB4);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      send_byte(rb);
    end
    send_eop();
    idle_bits(12);
    bus.buffer_occupancy = 7'd0;
    check_status("data1_rand", 3'd5, 1'b0);
    check("data1_stores", store_cnt, 3);
    check("data1_ready", ready_cnt, 1);

    // Reset during the second data byte
    send_byte(8'h80);
    send_byte(8'h33);
    exp_q.push_back(8'hAA);
    send_byte(8'hAA);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    #2;
    n_rst = 1'b0;
    dplus = 1'b1;
    dminus = 1'b0;
    line_j = 1'b1;
    #1;
    check("mrst_data",   bus.RX_packet_data, 0);
    check("mrst_store",  bus.store_RX_packet_data, 0);
    check("mrst_flush",  bus.flush, 0);
    check("mrst_packet", bus.RX_packet, 0);
    check("mrst_ready",  bus.RX_data_ready, 0);
    check("mrst_active", bus.RX_transfer_active, 0);
    check("mrst_error",  bus.RX_error, 0);
    check("mrst_state",  dbg_state, 0);
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    idle_bits(4);
    send_handshake(8'h2D);
    check_status("ack_after_rst", 3'd1, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
USB full-speed-style receive front end, the counterpart of tx_full_design. It samples dplus_in/dminus_in at BIT_PERIOD clocks per bit, recovers bit timing from line edges, and NRZI-decodes the stream LSB-first. It checks SYNC, decodes the PID and checks the token address, then writes data payload bytes into data_buffer64 through the RX_packet_data/store_RX_packet_data port. It reports the packet type, transfer activity and errors to the protocol controller.

Parameters:
BIT_PERIOD, 8, clocks per USB bit; a power of two is required.
DEVICE_ADDR, 7'd0, 7-bit address that OUT/IN tokens must match.
BUFFER_SIZE, 64, data buffer capacity in bytes.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
dplus_in  input  1  D+ line, asynchronous to clk
dminus_in  input  1  D- line, asynchronous to clk
buffer_occupancy  input  7  current data_buffer64 fill count
RX_packet_data  output  8  decoded payload byte, valid while store_RX_packet_data=1
store_RX_packet_data  output  1  one-cycle write strobe to the buffer
flush  output  1  one-cycle pulse that empties the buffer at DATA0/DATA1 PID accept
RX_packet  output  3  last packet: 0 NONE, 1 ACK, 2 NAK, 3 STALL, 4 DATA0, 5 DATA1, 6 OUT, 7 IN
RX_data_ready  output  1  one-cycle pulse at a clean EOP of a DATA packet
RX_transfer_active  output  1  high from SYNC start until EOP or error recovery
RX_error  output  1  sticky error flag; cleared at the next SYNC start

Behaviour:
- Reset values: RX_packet_data=0, store_RX_packet_data=0, flush=0, RX_packet=0, RX_data_ready=0, RX_transfer_active=0, RX_error=0, FSM=IDLE. Synchronizer flops reset to J (dplus=1, dminus=0).
- Input path: a 2-flop synchronizer on each line. The bit counter runs 0..BIT_PERIOD-1 and reloads to 0 on any change of synced dplus. The line is sampled when the count equals BIT_PERIOD/2-1.
- Line decode at each sample:
  - SE0 when dplus=dminus=0.
  - Otherwise decoded bit = ~(dplus ^ prev_dplus). prev_dplus updates only on non-SE0 samples.
- Bits shift in LSB-first. A byte completes on the 8th sample.
- Byte constants (decoded, LSB-first assembly): SYNC 8'h80, ACK 8'h2D, NAK 8'hA5, STALL 8'hE1, DATA0 8'h33, DATA1 8'hB4, OUT 8'h87, IN 8'h96.
- FSM:
  - IDLE: the first J->K edge goes to SYNC. Set RX_transfer_active=1 and clear RX_error. RX_packet holds its previous value.
  - SYNC: after 8 bits, if the byte is 8'h80 go to PID, else ERROR.
  - PID:
    - ACK/NAK/STALL: go to EOP.
    - DATA0/DATA1: pulse flush in the cycle after the byte completes, then go to DATA.
    - OUT/IN: go to TOKEN.
    - Any other value: ERROR.
    - RX_packet updates only at a clean EOP.
  - TOKEN: receive 2 bytes (addr[6:0]=first[6:0]; endpoint and CRC5 are ignored), then go to EOP.
  - DATA:
    - Each completed byte drives RX_packet_data and pulses store_RX_packet_data for 1 cycle, 1 clk after the completing sample.
    - If buffer_occupancy==BUFFER_SIZE when a byte completes, the byte is dropped and the FSM goes to ERROR.
    - SE0 at bit index 0 goes to EOP; SE0 at any other index goes to ERROR.
  - EOP: requires SE0 for 2 consecutive samples followed by one J sample.
    - On success, RX_packet = decoded type.
    - For DATA packets, pulse RX_data_ready 1 clk after the J sample.
    - For tokens, if addr != DEVICE_ADDR, RX_packet=0 and there is no error.
    - RX_transfer_active drops in the same cycle. Return to IDLE.
    - A non-SE0 sample where SE0 is expected goes to ERROR.
  - ERROR: set RX_error=1 and RX_packet=0. Hold RX_transfer_active=1 until BIT_PERIOD consecutive J samples, then go to IDLE.
- SE0 seen in SYNC, PID or TOKEN goes to ERROR.
- Reset asserted mid-packet returns immediately to the reset values. After reset the next SYNC decodes normally.

Optional Feature:
BIT_UNSTUFF_EN.
- Defined: after six consecutive decoded 1s, the next sample is discarded and does not shift into the byte. If that sample decodes to 1, go to ERROR (stuff violation). The 1-run count resets on 0 and on SE0.
- Undefined: no stuff logic is present and every sample is a data bit. This is the configuration that matches tx_full_design.

Test Plan:
- Drive ACK (SYNC 80, PID 2D, 2-bit SE0, J) at 8 clk/bit -> RX_packet=1 after EOP; RX_transfer_active 1 during the packet and 0 after; no store strobes; RX_error=0.
- DATA0 with bytes 01,02,03,04,05 -> flush pulses once; 5 store strobes carrying 01..05 in order; RX_data_ready pulses once; RX_packet=4.
- OUT token with addr 7'h05 and DEVICE_ADDR=5 -> RX_packet=6. Repeat with addr 7'h06 -> RX_packet=0 and RX_error=0.
- Corrupt SYNC to 8'h81, and separately send PID 8'h00 -> RX_error=1, RX_packet=0; the next valid NAK clears RX_error and gives RX_packet=2.
- DATA1 with buffer_occupancy held at 64 -> no store strobe, RX_error=1. SE0 after 3 bits of a data byte -> RX_error=1.
- Assert n_rst during the 2nd data byte -> all outputs return to their reset values asynchronously; a subsequent ACK decodes to RX_packet=1.
